// File: rtl/aq_fadd_norm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : aq_fadd_norm_pkg
// Brief  : Shared widths, constants and payload type for the FADD/FCNVT
//          normalization scheduler.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package aq_fadd_norm_pkg;

  localparam int DATA_W    = 54;
  localparam int EXP_W     = 13;
  localparam int TAG_W     = 4;
  localparam int SHIFT_W   = 6;
  localparam int EXP_FLOOR = 1;
  localparam logic [SHIFT_W-1:0] LZC_ZERO = 6'd54;

  typedef struct packed {
    logic [DATA_W-1:0] mant;
    logic [EXP_W-1:0]  expnt;
    logic [TAG_W-1:0]  tag;
    logic              src;
    logic              zero;
    logic              denorm;
  } norm_payload_t;

  // Shift headroom before the exponent would fall below the floor, capped at LZC_ZERO.
  function automatic logic [SHIFT_W-1:0] exp_room(input logic [EXP_W-1:0] expnt);
    logic signed [EXP_W:0] d;
    d = $signed({expnt[EXP_W-1], expnt}) - $signed((EXP_W+1)'(EXP_FLOOR));
    if (d <= 0)
      return '0;
    else if (d >= $signed((EXP_W+1)'(LZC_ZERO)))
      return LZC_ZERO;
    else
      return d[SHIFT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aq_fadd_norm_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : aq_fadd_norm_arb_if
// Brief  : Two request channels and the result channel of the scheduler.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
interface aq_fadd_norm_arb_if;
  import aq_fadd_norm_pkg::*;

  logic              req0_vld;
  logic              req0_rdy;
  logic [DATA_W-1:0] req0_mant;
  logic [EXP_W-1:0]  req0_expnt;
  logic [TAG_W-1:0]  req0_tag;

  logic              req1_vld;
  logic              req1_rdy;
  logic [DATA_W-1:0] req1_mant;
  logic [EXP_W-1:0]  req1_expnt;
  logic [TAG_W-1:0]  req1_tag;

  logic              out_vld;
  logic              out_rdy;
  logic [DATA_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_expnt;
  logic [TAG_W-1:0]  out_tag;
  logic              out_src;
  logic              out_zero;
  logic              out_denorm;

  modport slave (
    input  req0_vld, req0_mant, req0_expnt, req0_tag,
    input  req1_vld, req1_mant, req1_expnt, req1_tag,
    output req0_rdy, req1_rdy,
    input  out_rdy,
    output out_vld, out_mant, out_expnt, out_tag, out_src, out_zero, out_denorm
  );

  modport master (
    output req0_vld, req0_mant, req0_expnt, req0_tag,
    output req1_vld, req1_mant, req1_expnt, req1_tag,
    input  req0_rdy, req1_rdy,
    output out_rdy,
    input  out_vld, out_mant, out_expnt, out_tag, out_src, out_zero, out_denorm
  );

endinterface
`default_nettype wire

// File: rtl/aq_fadd_norm_lzc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : aq_fadd_norm_lzc
// Brief  : Combinational leading-zero counter; count is LZC_ZERO for zero input.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module aq_fadd_norm_lzc
  import aq_fadd_norm_pkg::*;
(
  input  logic [DATA_W-1:0]  i_mant,
  output logic [SHIFT_W-1:0] o_cnt,
  output logic               o_zero
);

  logic w_found;

  always_comb begin
    o_cnt   = LZC_ZERO;
    w_found = 1'b0;
    for (int i = DATA_W-1; i >= 0; i--) begin
      if (!w_found && i_mant[i]) begin
        o_cnt   = SHIFT_W'(DATA_W-1-i);
        w_found = 1'b1;
      end
    end
  end

  assign o_zero = ~|i_mant;

endmodule
`default_nettype wire

// File: rtl/aq_fadd_norm_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : aq_fadd_norm_arb
// Brief  : Round-robin FADD/FCNVT normalization scheduler, 2-stage valid/ready
//          pipeline. Define AQ_NORM_ARB_PERF_EN to add grant/conflict counters.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module aq_fadd_norm_arb
  import aq_fadd_norm_pkg::*;
(
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  aq_fadd_norm_arb_if.slave bus
`ifdef AQ_NORM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_grant0,
  output logic [15:0]       perf_grant1,
  output logic [15:0]       perf_conflict
`endif
);

  logic                r_rr_ptr;
  logic                r_s1_vld;
  logic [DATA_W-1:0]   r_s1_mant;
  logic [EXP_W-1:0]    r_s1_expnt;
  logic [TAG_W-1:0]    r_s1_tag;
  logic                r_s1_src;
  logic                r_s2_vld;
  norm_payload_t       r_s2;

  logic                w_s1_free;
  logic                w_s2_free;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_acc0;
  logic                w_acc1;
  logic [SHIFT_W-1:0]  w_lzc;
  logic                w_zero;
  logic [SHIFT_W-1:0]  w_room;
  logic [SHIFT_W-1:0]  w_shift;
  logic [SHIFT_W-1:0]  w_shift_eff;
  norm_payload_t       w_s2_next;

  assign w_s2_free = !r_s2_vld | bus.out_rdy;
  assign w_s1_free = !r_s1_vld | w_s2_free;

  assign w_gnt0 = bus.req0_vld & (!bus.req1_vld | !r_rr_ptr);
  assign w_gnt1 = bus.req1_vld & (!bus.req0_vld |  r_rr_ptr);

  assign bus.req0_rdy = !cpurst & w_s1_free & w_gnt0;
  assign bus.req1_rdy = !cpurst & w_s1_free & w_gnt1;

  assign w_acc0 = bus.req0_vld & bus.req0_rdy;
  assign w_acc1 = bus.req1_vld & bus.req1_rdy;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_rr_ptr   <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_s1_mant  <= '0;
      r_s1_expnt <= '0;
      r_s1_tag   <= '0;
      r_s1_src   <= 1'b0;
    end else begin
      if (w_s1_free) begin
        r_s1_vld <= w_acc0 | w_acc1;
        if (w_acc1) begin
          r_s1_mant  <= bus.req1_mant;
          r_s1_expnt <= bus.req1_expnt;
          r_s1_tag   <= bus.req1_tag;
          r_s1_src   <= 1'b1;
        end else if (w_acc0) begin
          r_s1_mant  <= bus.req0_mant;
          r_s1_expnt <= bus.req0_expnt;
          r_s1_tag   <= bus.req0_tag;
          r_s1_src   <= 1'b0;
        end
      end
      // Pointer favours whichever requester lost this handshake.
      if (w_acc0)
        r_rr_ptr <= 1'b1;
      else if (w_acc1)
        r_rr_ptr <= 1'b0;
    end
  end

  aq_fadd_norm_lzc u_lzc (
    .i_mant (r_s1_mant),
    .o_cnt  (w_lzc),
    .o_zero (w_zero)
  );

  assign w_room      = exp_room(r_s1_expnt);
  assign w_shift     = (w_lzc < w_room) ? w_lzc : w_room;
  // A zero mantissa can yield shift 54; keep it out of the shifter.
  assign w_shift_eff = w_zero ? '0 : w_shift;

  always_comb begin
    w_s2_next        = '0;
    w_s2_next.mant   = w_zero ? '0 : (r_s1_mant << w_shift_eff);
    w_s2_next.expnt  = w_zero ? '0
                     : (r_s1_expnt - {{(EXP_W-SHIFT_W){1'b0}}, w_shift_eff});
    w_s2_next.tag    = r_s1_tag;
    w_s2_next.src    = r_s1_src;
    w_s2_next.zero   = w_zero;
    w_s2_next.denorm = (w_room < w_lzc) & !w_zero;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_s2_vld <= 1'b0;
      r_s2     <= '0;
    end else if (w_s2_free) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld)
        r_s2 <= w_s2_next;
    end
  end

  assign bus.out_vld    = r_s2_vld;
  assign bus.out_mant   = r_s2.mant;
  assign bus.out_expnt  = r_s2.expnt;
  assign bus.out_tag    = r_s2.tag;
  assign bus.out_src    = r_s2.src;
  assign bus.out_zero   = r_s2.zero;
  assign bus.out_denorm = r_s2.denorm;

`ifdef AQ_NORM_ARB_PERF_EN
  logic [15:0] r_perf_g0;
  logic [15:0] r_perf_g1;
  logic [15:0] r_perf_cf;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_perf_g0 <= '0;
      r_perf_g1 <= '0;
      r_perf_cf <= '0;
    end else begin
      if (w_acc0 && r_perf_g0 != 16'hFFFF)
        r_perf_g0 <= r_perf_g0 + 16'd1;
      if (w_acc1 && r_perf_g1 != 16'hFFFF)
        r_perf_g1 <= r_perf_g1 + 16'd1;
      if (bus.req0_vld && bus.req1_vld && (w_acc0 || w_acc1) && r_perf_cf != 16'hFFFF)
        r_perf_cf <= r_perf_cf + 16'd1;
    end
  end

  assign perf_grant0   = r_perf_g0;
  assign perf_grant1   = r_perf_g1;
  assign perf_conflict = r_perf_cf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aq_fadd_norm_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_aq_fadd_norm_arb
// Brief  : Scoreboard bench for aq_fadd_norm_arb with directed vectors.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_aq_fadd_norm_arb;
  import aq_fadd_norm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aq_fadd_norm_arb_if bus();

`ifdef AQ_NORM_ARB_PERF_EN
  logic [15:0] pg0, pg1, pcf;
`endif

  aq_fadd_norm_arb dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus)
`ifdef AQ_NORM_ARB_PERF_EN
    ,
    .perf_grant0    (pg0),
    .perf_grant1    (pg1),
    .perf_conflict  (pcf)
`endif
  );

  typedef struct {
    logic [DATA_W-1:0] mant;
    logic [EXP_W-1:0]  expnt;
    logic [DATA_W-1:0] emant;
    logic [EXP_W-1:0]  eexp;
    logic              ezero;
    logic              eden;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] mant;
    logic [EXP_W-1:0]  expnt;
    logic [TAG_W-1:0]  tag;
    logic              src;
    logic              zero;
    logic              den;
  } exp_t;

  vec_t v0[5];
  vec_t v1[5];
  exp_t sb[$];
  int   gseq[$];
  int   c0 = 0;
  int   c1 = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic vec_t mk(logic [DATA_W-1:0] m, logic [EXP_W-1:0] e,
                              logic [DATA_W-1:0] em, logic [EXP_W-1:0] ee,
                              logic z, logic d);
    vec_t v;
    v.mant = m; v.expnt = e; v.emant = em; v.eexp = ee; v.ezero = z; v.eden = d;
    return v;
  endfunction

  task automatic push_exp(vec_t v, logic [TAG_W-1:0] tag, logic src);
    exp_t e;
    e.mant = v.emant; e.expnt = v.eexp; e.tag = tag; e.src = src;
    e.zero = v.ezero; e.den = v.eden;
    sb.push_back(e);
    gseq.push_back(int'(src));
  endtask

  // Called at posedge+1; each iteration covers one clock cycle.
  task automatic drive_cycles(int n, bit en0, bit en1, output int acc0, output int acc1);
    logic a0, a1;
    acc0 = 0;
    acc1 = 0;
    repeat (n) begin
      bus.req0_vld   = en0;
      bus.req0_mant  = v0[c0 % 5].mant;
      bus.req0_expnt = v0[c0 % 5].expnt;
      bus.req0_tag   = TAG_W'(c0);
      bus.req1_vld   = en1;
      bus.req1_mant  = v1[c1 % 5].mant;
      bus.req1_expnt = v1[c1 % 5].expnt;
      bus.req1_tag   = TAG_W'(c1 + 8);
      @(negedge clk);
      a0 = bus.req0_vld & bus.req0_rdy;
      a1 = bus.req1_vld & bus.req1_rdy;
      if (a0) push_exp(v0[c0 % 5], TAG_W'(c0), 1'b0);
      if (a1) push_exp(v1[c1 % 5], TAG_W'(c1 + 8), 1'b1);
      @(posedge clk);
      #1;
      if (a0) begin c0++; acc0++; end
      if (a1) begin c1++; acc1++; end
    end
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.req0_vld = 1'b1;
    bus.req1_vld = 1'b1;
    bus.out_rdy  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld",    64'(bus.out_vld),    64'h0);
    chk("rst_out_mant",   64'(bus.out_mant),   64'h0);
    chk("rst_out_expnt",  64'(bus.out_expnt),  64'h0);
    chk("rst_out_tag",    64'(bus.out_tag),    64'h0);
    chk("rst_out_src",    64'(bus.out_src),    64'h0);
    chk("rst_out_zero",   64'(bus.out_zero),   64'h0);
    chk("rst_out_denorm", 64'(bus.out_denorm), 64'h0);
    chk("rst_req0_rdy",   64'(bus.req0_rdy),   64'h0);
    chk("rst_req1_rdy",   64'(bus.req1_rdy),   64'h0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
    sb.delete();
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_vld && bus.out_rdy) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got tag %0h src %0h, expected no output",
                   bus.out_tag, bus.out_src);
        end else begin
          e = sb.pop_front();
          chk("out_mant",   64'(bus.out_mant),   64'(e.mant));
          chk("out_expnt",  64'(bus.out_expnt),  64'(e.expnt));
          chk("out_tag",    64'(bus.out_tag),    64'(e.tag));
          chk("out_src",    64'(bus.out_src),    64'(e.src));
          chk("out_zero",   64'(bus.out_zero),   64'(e.zero));
          chk("out_denorm", 64'(bus.out_denorm), 64'(e.den));
        end
      end
    end
  end

  initial begin
    int a0, a1, t0, t1;
    logic [DATA_W-1:0] s_mant;
    logic [EXP_W-1:0]  s_exp;
    logic [TAG_W-1:0]  s_tag;

    v0[0] = mk(54'hF0,                 13'd100,  54'h3C_0000_0000_0000, 13'd54,   1'b0, 1'b0);
    v0[1] = mk(54'h1_0000,             13'd5,    54'h10_0000,           13'd1,    1'b0, 1'b1);
    v0[2] = mk(54'h0,                  13'd300,  54'h0,                 13'd0,    1'b1, 1'b0);
    v0[3] = mk(54'h20_0000_0000_0000,  13'd1,    54'h20_0000_0000_0000, 13'd1,    1'b0, 1'b0);
    v0[4] = mk(54'h1,                  13'd54,   54'h20_0000_0000_0000, 13'd1,    1'b0, 1'b0);
    v1[0] = mk(54'h1,                  13'd0,    54'h1,                 13'd0,    1'b0, 1'b1);
    v1[1] = mk(54'h1,                  13'd60,   54'h20_0000_0000_0000, 13'd7,    1'b0, 1'b0);
    v1[2] = mk(54'h3,                  13'h1FFB, 54'h3,                 13'h1FFB, 1'b0, 1'b1);
    v1[3] = mk(54'h00_00FF_0000_0000,  13'd20,   54'h3F_C000_0000_0000, 13'd6,    1'b0, 1'b0);
    v1[4] = mk(54'h0,                  13'd0,    54'h0,                 13'd0,    1'b1, 1'b0);

    bus.req0_vld = 1'b0; bus.req0_mant = '0; bus.req0_expnt = '0; bus.req0_tag = '0;
    bus.req1_vld = 1'b0; bus.req1_mant = '0; bus.req1_expnt = '0; bus.req1_tag = '0;
    bus.out_rdy  = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Latency: single accept, result two cycles later.
    drive_cycles(1, 1'b1, 1'b0, a0, a1);
    chk("lat_accept", 64'(a0), 64'd1);
    @(negedge clk);
    chk("lat_cycle1_vld", 64'(bus.out_vld), 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_cycle2_vld", 64'(bus.out_vld), 64'h1);
    @(posedge clk);
    #1;

    // Back-to-back streams from each requester.
    drive_cycles(4, 1'b1, 1'b0, a0, a1);
    chk("stream0_acc", 64'(a0), 64'd4);
    drive_cycles(5, 1'b0, 1'b1, a0, a1);
    chk("stream1_acc", 64'(a1), 64'd5);
    idle(4);

    // Round-robin with both requesters valid.
    do_reset();
    gseq.delete();
    drive_cycles(6, 1'b1, 1'b1, a0, a1);
    chk("rr_count", 64'(gseq.size()), 64'd6);
    if (gseq.size() == 6) begin
      chk("rr_g0", 64'(gseq[0]), 64'd0);
      chk("rr_g1", 64'(gseq[1]), 64'd1);
      chk("rr_g2", 64'(gseq[2]), 64'd0);
      chk("rr_g3", 64'(gseq[3]), 64'd1);
      chk("rr_g4", 64'(gseq[4]), 64'd0);
      chk("rr_g5", 64'(gseq[5]), 64'd1);
    end
    idle(4);
`ifdef AQ_NORM_ARB_PERF_EN
    chk("perf_grant0",   64'(pg0), 64'd3);
    chk("perf_grant1",   64'(pg1), 64'd3);
    chk("perf_conflict", 64'(pcf), 64'd6);
`endif

    // Back-pressure: only two ops fit, outputs hold while stalled.
    bus.out_rdy = 1'b0;
    drive_cycles(2, 1'b1, 1'b0, t0, a1);
    @(negedge clk);
    s_mant = bus.out_mant;
    s_exp  = bus.out_expnt;
    s_tag  = bus.out_tag;
    @(posedge clk);
    #1;
    drive_cycles(2, 1'b1, 1'b0, t1, a1);
    chk("stall_acc", 64'(t0 + t1), 64'd2);
    bus.req0_vld = 1'b1;
    @(negedge clk);
    chk("stall_req0_rdy", 64'(bus.req0_rdy), 64'h0);
    chk("stall_out_vld",  64'(bus.out_vld),  64'h1);
    chk("stall_hold_mant",  64'(bus.out_mant),  64'(s_mant));
    chk("stall_hold_expnt", 64'(bus.out_expnt), 64'(s_exp));
    chk("stall_hold_tag",   64'(bus.out_tag),   64'(s_tag));
    @(posedge clk);
    #1;
    bus.req0_vld = 1'b0;
    bus.out_rdy  = 1'b1;
    idle(4);
    chk("stall_drained", 64'(sb.size()), 64'd0);

    // Reset with both stages full, last grant to req0.
    bus.out_rdy = 1'b0;
    drive_cycles(4, 1'b1, 1'b0, a0, a1);
    chk("flush_fill", 64'(a0), 64'd2);
    do_reset();
    gseq.delete();
    drive_cycles(2, 1'b1, 1'b1, a0, a1);
    chk("post_rst_cnt", 64'(gseq.size()), 64'd2);
    if (gseq.size() == 2) begin
      chk("post_rst_g0", 64'(gseq[0]), 64'd0);
      chk("post_rst_g1", 64'(gseq[1]), 64'd1);
    end

    // Bounded drain; anything left is a lost result.
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(4);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
